// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned BaudW    = 8;
  localparam logic        LineIdle = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone
  } tx_state_e;

endpackage

// File: rtl/tx_shift.sv
// UART 8N1 transmit shift engine: latches a byte on request, serialises it LSB first,
// and pulses o_Pready for one cycle once the stop bit has been sent.
module tx_shift
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DataBits,
  parameter int unsigned BAUD_W    = BaudW
) (
  input  logic                 i_Pclk,
  input  logic                 i_Presetn,
  input  logic [BAUD_W-1:0]    i_Baud,
  input  logic                 i_Enable,
  input  logic [DATA_BITS-1:0] i_Pwdata,
  output logic                 o_Tx_Serial,
  output logic                 o_Pready
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DATA_BITS - 1);
  localparam logic [BAUD_W-1:0] TimerOne = BAUD_W'(1);

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      timer_q, timer_d;
  logic [BAUD_W-1:0]      bmax_q, bmax_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   tx_q, tx_d;
  logic                   pready_q, pready_d;
  logic                   bit_end;

  // bmax holds P-1 for the frame in flight, so a zero baud setting means one cycle per bit.
  assign bit_end = (timer_q == bmax_q);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bmax_d  = bmax_q;
    idx_d   = idx_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle: begin
        if (i_Enable) begin
          data_d  = i_Pwdata;
          bmax_d  = (i_Baud == '0) ? '0 : (i_Baud - TimerOne);
          timer_d = '0;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StData: begin
        if (bit_end) begin
          timer_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    tx_d     = LineIdle;
    pready_d = 1'b0;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = data_d[idx_d];
      StDone:  pready_d = 1'b1;
      default: tx_d = LineIdle;
    endcase
  end

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bmax_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      tx_q     <= LineIdle;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bmax_q   <= bmax_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      pready_q <= pready_d;
    end
  end

  assign o_Tx_Serial = tx_q;
  assign o_Pready    = pready_q;

endmodule

// File: tb/tb_tx_shift.sv
// Self-checking bench for tx_shift: a frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tx_shift;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] baud = 8'd0;
  logic       en = 1'b0;
  logic [7:0] pwdata = 8'd0;
  logic       line;
  logic       rdy;

  int tests = 0;
  int fails = 0;

  tx_shift dut (
    .i_Pclk     (clk),
    .i_Presetn  (rst_n),
    .i_Baud     (baud),
    .i_Enable   (en),
    .i_Pwdata   (pwdata),
    .o_Tx_Serial(line),
    .o_Pready   (rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a frame is 10 bit slots of P cycles counted from acceptance,
  // then one ready cycle, then back to idle.
  logic       m_busy = 1'b0;
  int         m_n = 0;
  int         m_p = 1;
  logic [9:0] m_frame = 10'h3ff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_n    = 0;
    end else if (!m_busy) begin
      if (en) begin
        m_busy  = 1'b1;
        m_n     = 0;
        m_p     = (baud == 8'd0) ? 1 : int'(baud);
        m_frame = {1'b1, pwdata, 1'b0};
      end
    end else begin
      m_n++;
      if (m_n == 10 * m_p + 1) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic exp_line;
    logic exp_rdy;
    exp_line = 1'b1;
    exp_rdy  = 1'b0;
    if (m_busy) begin
      if (m_n < 10 * m_p) exp_line = m_frame[m_n / m_p];
      else if (m_n == 10 * m_p) exp_rdy = 1'b1;
    end
    check("model_line", {31'd0, line}, {31'd0, exp_line});
    check("model_pready", {31'd0, rdy}, {31'd0, exp_rdy});
  end

  initial begin
    int         cnt;
    int         bad;
    logic [9:0] f2;
    logic [9:0] f6;
    f2 = 10'b1010100010;  // 0x51 framed, bit k = slot k
    f6 = 10'b1101001010;  // 0xA5 framed

    // 1: idle after reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (line !== 1'b1) bad++;
      if (rdy !== 1'b0) cnt++;
    end
    check("s1_line_high", bad, 0);
    check("s1_no_pready", cnt, 0);

    // 2 + 3: 0x51 at P=87, inputs disturbed mid-frame
    @(negedge clk);
    baud = 8'd87; pwdata = 8'h51; en = 1'b1;
    cnt = 0;
    for (int n = 0; n < 870; n++) begin
      @(negedge clk);
      if (n == 10) begin
        pwdata = 8'h00; baud = 8'd10;
      end
      if ((n % 87) == 0 || (n % 87) == 86) check("s2_bit", {31'd0, line}, {31'd0, f2[n / 87]});
      if (rdy) cnt++;
    end
    check("s2_no_early_pready", cnt, 0);
    @(negedge clk);
    check("s2_pready", {31'd0, rdy}, 32'd1);
    check("s2_done_line", {31'd0, line}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("s2_pready_clear", {31'd0, rdy}, 32'd0);
    check("s2_idle_line", {31'd0, line}, 32'd1);

    // 4: back-to-back, P=4, 0xFF then 0x00
    @(negedge clk);
    baud = 8'd4; pwdata = 8'hFF; en = 1'b1;
    cnt = 0;
    for (int n = 0; n < 84; n++) begin
      @(negedge clk);
      if (n == 5) pwdata = 8'h00;
      if (rdy) cnt++;
      if (n == 4)  check("s4_ff_bit0", {31'd0, line}, 32'd1);
      if (n == 40) check("s4_pready1", {31'd0, rdy}, 32'd1);
      if (n == 41) check("s4_gap_line", {31'd0, line}, 32'd1);
      if (n == 42) check("s4_start2", {31'd0, line}, 32'd0);
      if (n == 46) check("s4_00_bit0", {31'd0, line}, 32'd0);
      if (n == 81) check("s4_stop2", {31'd0, line}, 32'd1);
      if (n == 82) begin
        check("s4_pready2", {31'd0, rdy}, 32'd1);
        en = 1'b0;
      end
    end
    check("s4_pulse_count", cnt, 2);

    // 5: reset during data bit 3
    @(negedge clk);
    baud = 8'd5; pwdata = 8'h3C; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (22) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("s5_rst_line", {31'd0, line}, 32'd1);
    check("s5_rst_pready", {31'd0, rdy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    check("s5_no_pready", cnt, 0);

    // 6: baud 0 means one cycle per bit
    @(negedge clk);
    baud = 8'd0; pwdata = 8'hA5; en = 1'b1;
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (n < 10) check("s6_bit", {31'd0, line}, {31'd0, f6[n]});
      else check("s6_pready", {31'd0, rdy}, 32'd1);
    end
    repeat (2) @(negedge clk);

    // Randomized traffic, including occasional mid-frame reset and baud changes.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
      en     = ($urandom_range(0, 3) != 0);
      pwdata = 8'($urandom);
      if ($urandom_range(0, 49) == 0) baud = 8'($urandom_range(0, 6));
    end
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
